alu_seq_ctrl: RTL

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl_pkg.sv | 36 +++
 rtl/alu_seq_ctrl_alu.sv | 63 ++++++
 rtl/alu_seq_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/alu_seq_ctrl_pkg.sv
// Shared encodings for the sequenced ALU controller: command selects, FSM states,
// ALU opcodes and the layout of the flag field stored beside each result.
package alu_seq_ctrl_pkg;

    // Command type carried on in_sel
    localparam logic [1:0] SelLoadA  = 2'b00;
    localparam logic [1:0] SelLoadB  = 2'b01;
    localparam logic [1:0] SelLoadOp = 2'b10;
    localparam logic [1:0] SelGo     = 2'b11;

    // Flag field layout, PF in the least significant bit
    localparam int unsigned FLAG_W = 5;
    localparam int unsigned FlagPf = 0;
    localparam int unsigned FlagSf = 1;
    localparam int unsigned FlagOf = 2;
    localparam int unsigned FlagCf = 3;
    localparam int unsigned FlagZf = 4;

    typedef enum logic {
        StIdle,
        StExec
    } state_e;

    // Opcodes understood by the ALU; any other code yields a zero result
    typedef enum logic [3:0] {
        AluAdd = 4'd0,
        AluSub = 4'd1,
        AluAnd = 4'd2,
        AluOr  = 4'd3,
        AluXor = 4'd4,
        AluShl = 4'd5,
        AluShr = 4'd6,
        AluSra = 4'd7
    } alu_op_e;

endpackage

// File: rtl/alu_seq_ctrl_alu.sv
// Combinational ALU: result F plus ZF/CF/OF/SF/PF. CF is carry-out for add and
// borrow for subtract; PF is set when the result has an even number of ones.
module alu_seq_ctrl_alu
    import alu_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [3:0]        op,
    output logic [WIDTH-1:0]  f,
    output logic [FLAG_W-1:0] flags
);

    localparam int unsigned SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH:0]   ext;
    logic [SHW-1:0]   shamt;
    logic             carry;
    logic             ovf;

    assign shamt = b[SHW-1:0];

    // Operation decode with carry and signed-overflow generation
    always_comb begin
        ext   = '0;
        f     = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (op)
            AluAdd: begin
                ext   = {1'b0, a} + {1'b0, b};
                f     = ext[WIDTH-1:0];
                carry = ext[WIDTH];
                ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (f[WIDTH-1] != a[WIDTH-1]);
            end
            AluSub: begin
                ext   = {1'b0, a} - {1'b0, b};
                f     = ext[WIDTH-1:0];
                carry = ext[WIDTH];
                ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (f[WIDTH-1] != a[WIDTH-1]);
            end
            AluAnd: f = a & b;
            AluOr:  f = a | b;
            AluXor: f = a ^ b;
            AluShl: f = a << shamt;
            AluShr: f = a >> shamt;
            AluSra: f = WIDTH'($signed(a) >>> shamt);
            default: f = '0;
        endcase
    end

    // Flag assembly from the selected result
    always_comb begin
        flags         = '0;
        flags[FlagZf] = (f == '0);
        flags[FlagCf] = carry;
        flags[FlagOf] = ovf;
        flags[FlagSf] = f[WIDTH-1];
        flags[FlagPf] = ~^f;
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command-driven ALU sequencer: operands and opcode are loaded by command words,
// GO runs one ALU operation whose result and flags are queued in a small FIFO.
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OP_W  = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             out_sel,
    output logic [WIDTH-1:0] out_data,
    output logic [15:0]      op_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam logic [LVL_W-1:0] LvlFull = LVL_W'(DEPTH);

    typedef struct packed {
        logic [FLAG_W-1:0] flags;
        logic [WIDTH-1:0]  result;
    } entry_t;

    state_e            state_q;
    logic              in_ready_q;
    logic [15:0]       op_count_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [OP_W-1:0]   op_q;

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_d;

    logic              accept;
    logic              go;
    logic              push;
    logic              pop;
    entry_t            head;

    logic [3:0]        alu_op;
    logic [WIDTH-1:0]  alu_f;
    logic [FLAG_W-1:0] alu_flags;

    assign in_ready  = in_ready_q;
    assign op_count  = op_count_q;
    assign out_valid = (level_q != '0);
    assign alu_op    = 4'(op_q);
    assign head      = mem_q[rd_ptr_q];

    // Handshake decode and next FIFO level
    always_comb begin
        accept  = in_valid && in_ready_q;
        go      = accept && (in_sel == SelGo);
        push    = (state_q == StExec);
        pop     = out_valid && out_ready;
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!push && pop) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // Sequencer FSM; in_ready is registered from the level the FIFO will hold next
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            in_ready_q <= 1'b1;
            op_count_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (go) begin
                        state_q    <= StExec;
                        in_ready_q <= 1'b0;
                    end else begin
                        in_ready_q <= (level_d != LvlFull);
                    end
                end
                StExec: begin
                    state_q    <= StIdle;
                    op_count_q <= op_count_q + 16'd1;
                    in_ready_q <= (level_d != LvlFull);
                end
                default: begin
                    state_q    <= StIdle;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Operand and opcode registers, written only by accepted load commands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
        end else if (accept) begin
            case (in_sel)
                SelLoadA:  a_q  <= in_data;
                SelLoadB:  b_q  <= in_data;
                SelLoadOp: op_q <= in_data[OP_W-1:0];
                default:   ;
            endcase
        end
    end

    // FIFO pointers and level; a GO is only taken below full, so EXEC never overflows
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            level_q <= level_d;
        end
    end

    // FIFO storage; contents are never visible while empty, so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{flags: alu_flags, result: alu_f};
        end
    end

    // Head field selection, forced to zero when the FIFO is empty
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            if (out_sel) begin
                out_data = WIDTH'(head.flags);
            end else begin
                out_data = head.result;
            end
        end
    end

    alu_seq_ctrl_alu #(
        .WIDTH (WIDTH)
    ) alu (
        .a     (a_q),
        .b     (b_q),
        .op    (alu_op),
        .f     (alu_f),
        .flags (alu_flags)
    );

endmodule
